// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register: one main entry plus one skid entry under a valid/ready
// handshake, with synchronous flush and a saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int unsigned WIDTH          = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Payload registers only load from in_data on an accepted handshake, never when invalid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // in_ready comes from registered state only, so out_ready never reaches it combinationally.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      StOne: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      StFull: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (cnt_clr) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  assign out_data  = main_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a default instance and a narrow-counter,
// no-clear-on-flush instance driven by the same stimulus.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, cnt_clr;
  logic [31:0] in_data;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic [2:0]  b_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .WIDTH         (32),
    .CLEAR_ON_FLUSH(1'b1),
    .CNT_W         (16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (a_in_ready),
    .in_data  (in_data),
    .out_valid(a_out_valid),
    .out_ready(out_ready),
    .out_data (a_out_data),
    .occupancy(a_occ),
    .stall_cnt(a_stall),
    .cnt_clr  (cnt_clr)
  );

  pipe_stage_skid #(
    .WIDTH         (32),
    .CLEAR_ON_FLUSH(1'b0),
    .CNT_W         (3)
  ) u_sat (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (b_in_ready),
    .in_data  (in_data),
    .out_valid(b_out_valid),
    .out_ready(out_ready),
    .out_data (b_out_data),
    .occupancy(b_occ),
    .stall_cnt(b_stall),
    .cnt_clr  (cnt_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic rdy, input logic [31:0] d,
                       input logic [1:0] occ);
    chk({tag, ".out_valid"}, {31'd0, a_out_valid}, {31'd0, v});
    chk({tag, ".in_ready"}, {31'd0, a_in_ready}, {31'd0, rdy});
    chk({tag, ".out_data"}, a_out_data, d);
    chk({tag, ".occupancy"}, {30'd0, a_occ}, {30'd0, occ});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_data = '0;
    tick();
    tick();
    chk_a("reset", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("reset.stall", {16'd0, a_stall}, 32'd0);
    chk("reset.b_stall", {29'd0, b_stall}, 32'd0);
    rst = 1'b0;

    // Streaming 1..8 with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      tick();
      chk_a($sformatf("stream%0d", i), 1'b1, 1'b1, i, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_a("stream_drain", 1'b0, 1'b1, 32'h8, 2'd0);
    chk("stream.stall", {16'd0, a_stall}, 32'd0);

    // Skid fill: A, B held, C waits upstream
    in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
    tick();
    chk_a("skid_a", 1'b1, 1'b1, 32'hA, 2'd1);
    in_data = 32'hB;
    tick();
    chk_a("skid_full", 1'b1, 1'b0, 32'hA, 2'd2);
    chk("skid.stall1", {16'd0, a_stall}, 32'd1);
    in_data = 32'hC;
    tick();
    chk_a("skid_hold1", 1'b1, 1'b0, 32'hA, 2'd2);
    tick();
    chk_a("skid_hold2", 1'b1, 1'b0, 32'hA, 2'd2);
    chk("skid.stall3", {16'd0, a_stall}, 32'd3);
    out_ready = 1'b1;
    tick();
    chk_a("skid_pop_b", 1'b1, 1'b1, 32'hB, 2'd1);
    tick();
    chk_a("skid_pop_c", 1'b1, 1'b1, 32'hC, 2'd1);
    in_valid = 1'b0;
    tick();
    chk_a("skid_empty", 1'b0, 1'b1, 32'hC, 2'd0);
    chk("skid.stall_final", {16'd0, a_stall}, 32'd3);
    chk("skid.b_stall_final", {29'd0, b_stall}, 32'd3);

    // Flush while FULL with in_valid high and out_ready low
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
    tick();
    in_data = 32'h22;
    tick();
    chk_a("fflush_pre", 1'b1, 1'b0, 32'h11, 2'd2);
    flush = 1'b1; in_data = 32'h33;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_a("fflush_post", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("fflush.b_data_held", b_out_data, 32'h11);
    chk("fflush.b_occ", {30'd0, b_occ}, 32'd0);
    chk("fflush.stall_kept", {16'd0, a_stall}, 32'd5);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr.stall", {16'd0, a_stall}, 32'd0);

    // Flush in ONE with accept of 0x55 and pop in the same cycle
    in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b0;
    tick();
    in_data = 32'h55; out_ready = 1'b1; flush = 1'b1;
    chk_a("oflush_pop_visible", 1'b1, 1'b1, 32'h44, 2'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_a("oflush_post", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("oflush.b_dropped", b_out_data, 32'h44);
    chk("oflush.b_valid", {31'd0, b_out_valid}, 32'd0);
    chk("oflush.stall", {16'd0, a_stall}, 32'd0);

    // Counter saturation on the 3-bit instance
    in_valid = 1'b1; in_data = 32'h66; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("sat.b_stall", {29'd0, b_stall}, 32'd7);
    chk("sat.a_stall", {16'd0, a_stall}, 32'd10);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat.b_clr", {29'd0, b_stall}, 32'd0);
    chk("sat.a_clr", {16'd0, a_stall}, 32'd0);
    tick();
    chk("sat.b_restart", {29'd0, b_stall}, 32'd1);

    // Reset while FULL overrides flush and cnt_clr
    in_valid = 1'b1; in_data = 32'h77;
    tick();
    chk_a("rfull_pre", 1'b1, 1'b0, 32'h66, 2'd2);
    rst = 1'b1; flush = 1'b1; cnt_clr = 1'b1; in_data = 32'h88;
    tick();
    chk_a("rfull_rst", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("rfull.stall", {16'd0, a_stall}, 32'd0);
    chk("rfull.b_data", b_out_data, 32'h0);
    chk("rfull.b_stall", {29'd0, b_stall}, 32'd0);
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_a("rfull_after", 1'b0, 1'b1, 32'h0, 2'd0);
    chk("rfull.b_after", b_out_data, 32'h0);
    chk("rfull.b_valid", {31'd0, b_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
